player_motion_ctrl: RTL
=======================

// Module: player_motion_ctrl
// PURPOSE
// Per-player position engine upstream of the game renderer. Synchronises a raw
// 4-bit move request, advances the player sprite's top-left position once per
// movement frame, clamps it inside the walled play area, and raises per-side
// wall-collision flags followed by a short stun. Instantiated once per player;
// its outputs drive player_N_x/y and the collide_with_wall_* flags.
// PARAMETERS
// SCREEN_W     640  visible width in pixels
// SCREEN_H     480  visible height in pixels
// WALL_THICK   8    wall thickness on all four edges in pixels
// PLAYER_SIZE  16   square sprite edge in pixels
// START_X      312  reset/respawn x; must lie in [X_MIN, X_MAX]
// START_Y      232  reset/respawn y; must lie in [Y_MIN, Y_MAX]
// STEP         2    pixels moved per movement frame per axis, 1..WALL_THICK
// MOVE_DIV     1    frame ticks per movement frame, >=1
// STUN_FRAMES  4    frame ticks frozen after a wall hit, >=1
// PORTS
// clk_i            in   1   system clock (pixel clock domain)
// reset_i          in   1   asynchronous, active-low reset
// frame_tick_i     in   1   one-cycle pulse, once per video frame (vblank start)
// move_i           in   4   raw request: [0]=up [1]=down [2]=left [3]=right
// respawn_i        in   1   synchronous: return to START_X/START_Y
// player_x_o       out  10  sprite top-left x
// player_y_o       out  10  sprite top-left y
// collide_top_o    out  1   hit top wall on last movement frame
// collide_bottom_o out  1   hit bottom wall on last movement frame
// collide_left_o   out  1   hit left wall on last movement frame
// collide_right_o  out  1   hit right wall on last movement frame
// moving_o         out  1   position changed on last movement frame
// BEHAVIOUR
// - Bounds: X_MIN=WALL_THICK, X_MAX=SCREEN_W-WALL_THICK-PLAYER_SIZE (616),
//   Y_MIN=WALL_THICK, Y_MAX=SCREEN_H-WALL_THICK-PLAYER_SIZE (456).
// - Reset (reset_i=0, no clock needed): x=START_X, y=START_Y, all collide_*=0,
//   moving_o=0, state IDLE, divider and stun counters 0, sync flops 0.
// - move_i passes a 2-flop synchroniser; value must be stable >=2 clk before tick.
// - Direction decode per axis: up&down or left&right -> axis delta 0; else +/-STEP.
// - Divider counts frame_tick_i 0..MOVE_DIV-1; the tick at count MOVE_DIV-1 is a
//   movement frame. Divider runs in all states; respawn clears it.
// - FSM: IDLE -> MOVE on movement frame with nonzero delta and no hit.
//   IDLE/MOVE -> STUN on movement frame where any axis hits a wall.
//   MOVE -> IDLE on movement frame with zero delta.
//   STUN: moves ignored; stun counter loaded STUN_FRAMES on entry, decremented on
//   every frame_tick_i; at 0 -> IDLE (next movement frame evaluated normally).
// - Update (registered, visible the cycle after the movement-frame tick): compute
//   target per axis in 11-bit signed; target<MIN -> clamp to MIN, set collide on
//   that side; target>MAX -> clamp to MAX, set collide. Both axes independent;
//   diagonal may flag two sides. Already at MAX and pushing further = hit.
// - collide_* and moving_o are rewritten on every movement frame (cleared if no
//   event); held in between. In STUN, movement frames clear them, position frozen.
// - respawn_i has priority over frame_tick_i in the same cycle: position to START,
//   flags/moving 0, state IDLE, counters 0; the coincident tick is discarded.
// - Reset asserted mid-STUN or mid-move: immediate return to reset values.
// TESTING
// - Release reset -> x=312,y=232, all collide_*=0, moving_o=0.
// - move_i=4'b1000 held, one tick -> next cycle x=314,y=232, moving_o=1.
// - x at 614, right held: tick1 -> x=616 no flag; tick2 -> x=616, collide_right_o=1,
//   moving_o=0; next 4 ticks with left held -> x stays 616; 5th tick -> x=614.
// - move_i=4'b0011 -> y unchanged, moving_o=0; move_i=4'b1001 -> x+2,y-2.
// - MOVE_DIV=3: 3 ticks with right held -> x changes only after 3rd tick (+2).
// - respawn_i with frame_tick_i same cycle from (616,456) -> (312,232), flags 0;
//   reset_i low mid-STUN without clock -> outputs at reset values immediately.

Source files
------------

// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl
// Per-player position engine. Synchronises a raw move request and advances the
// sprite's top-left corner once per movement frame. The position is clamped
// inside the walled play area. A wall hit raises per-side collision flags and
// then freezes the player for a short stun.
//
// Ports
//   clk_i             system clock (pixel clock domain)
//   reset_i           asynchronous active-low reset
//   frame_tick_i      one-cycle pulse once per video frame
//   move_i[3:0]       raw request: [0]=up [1]=down [2]=left [3]=right
//   respawn_i         synchronous return to the start position
//   player_x_o[9:0]   sprite top-left x
//   player_y_o[9:0]   sprite top-left y
//   collide_*_o       wall hit on that side during the last movement frame
//   moving_o          position changed during the last movement frame
module player_motion_ctrl #(
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned SCREEN_H    = 480,
  parameter int unsigned WALL_THICK  = 8,
  parameter int unsigned PLAYER_SIZE = 16,
  parameter int unsigned START_X     = 312,
  parameter int unsigned START_Y     = 232,
  parameter int unsigned STEP        = 2,
  parameter int unsigned MOVE_DIV    = 1,
  parameter int unsigned STUN_FRAMES = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       frame_tick_i,
  input  logic [3:0] move_i,
  input  logic       respawn_i,
  output logic [9:0] player_x_o,
  output logic [9:0] player_y_o,
  output logic       collide_top_o,
  output logic       collide_bottom_o,
  output logic       collide_left_o,
  output logic       collide_right_o,
  output logic       moving_o
);

  localparam int unsigned DIV_W  = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int unsigned STUN_W = $clog2(STUN_FRAMES + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(MOVE_DIV - 1);
  localparam logic [STUN_W-1:0] STUN_LOAD = STUN_W'(STUN_FRAMES);
  localparam logic [STUN_W-1:0] STUN_ONE  = STUN_W'(1);
  localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);

  localparam logic [9:0] X_MIN   = 10'(WALL_THICK);
  localparam logic [9:0] X_MAX   = 10'(SCREEN_W - WALL_THICK - PLAYER_SIZE);
  localparam logic [9:0] Y_MIN   = 10'(WALL_THICK);
  localparam logic [9:0] Y_MAX   = 10'(SCREEN_H - WALL_THICK - PLAYER_SIZE);
  localparam logic [9:0] X_START = 10'(START_X);
  localparam logic [9:0] Y_START = 10'(START_Y);

  // Bounds and step widened to 11-bit signed so an under/overshoot stays visible.
  localparam logic signed [10:0] X_MIN_S = $signed({1'b0, X_MIN});
  localparam logic signed [10:0] X_MAX_S = $signed({1'b0, X_MAX});
  localparam logic signed [10:0] Y_MIN_S = $signed({1'b0, Y_MIN});
  localparam logic signed [10:0] Y_MAX_S = $signed({1'b0, Y_MAX});
  localparam logic signed [10:0] STEP_S  = 11'(STEP);

  typedef enum logic [1:0] {StIdle, StMove, StStun} state_e;

  state_e             state;
  logic [3:0]         move_s1, move_s2;
  logic [DIV_W-1:0]   div_cnt;
  logic [STUN_W-1:0]  stun_cnt;

  logic               move_frame;
  logic signed [10:0] dx, dy, tx, ty;
  logic               hit_l, hit_r, hit_t, hit_b, any_hit, nonzero;
  logic [9:0]         nx, ny;

  // Two-flop synchroniser for the asynchronous move request.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      move_s1 <= '0;
      move_s2 <= '0;
    end else begin
      move_s1 <= move_i;
      move_s2 <= move_s1;
    end
  end

  always_comb begin
    move_frame = frame_tick_i && (div_cnt == DIV_LAST);

    // Opposing requests on one axis cancel.
    dx = '0;
    if (move_s2[3] && !move_s2[2])      dx = STEP_S;
    else if (move_s2[2] && !move_s2[3]) dx = -STEP_S;
    dy = '0;
    if (move_s2[1] && !move_s2[0])      dy = STEP_S;
    else if (move_s2[0] && !move_s2[1]) dy = -STEP_S;

    tx = $signed({1'b0, player_x_o}) + dx;
    ty = $signed({1'b0, player_y_o}) + dy;

    hit_l = tx < X_MIN_S;
    hit_r = tx > X_MAX_S;
    hit_t = ty < Y_MIN_S;
    hit_b = ty > Y_MAX_S;

    nx = hit_l ? X_MIN : (hit_r ? X_MAX : tx[9:0]);
    ny = hit_t ? Y_MIN : (hit_b ? Y_MAX : ty[9:0]);

    any_hit = hit_l || hit_r || hit_t || hit_b;
    nonzero = (dx != '0) || (dy != '0);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state            <= StIdle;
      div_cnt          <= '0;
      stun_cnt         <= '0;
      player_x_o       <= X_START;
      player_y_o       <= Y_START;
      collide_top_o    <= 1'b0;
      collide_bottom_o <= 1'b0;
      collide_left_o   <= 1'b0;
      collide_right_o  <= 1'b0;
      moving_o         <= 1'b0;
    end else if (respawn_i) begin
      // Respawn wins over a coincident tick; that tick is dropped entirely.
      state            <= StIdle;
      div_cnt          <= '0;
      stun_cnt         <= '0;
      player_x_o       <= X_START;
      player_y_o       <= Y_START;
      collide_top_o    <= 1'b0;
      collide_bottom_o <= 1'b0;
      collide_left_o   <= 1'b0;
      collide_right_o  <= 1'b0;
      moving_o         <= 1'b0;
    end else if (frame_tick_i) begin
      div_cnt <= move_frame ? '0 : div_cnt + DIV_ONE;
      case (state)
        StStun: begin
          // Frozen: movement frames only clear the event flags.
          if (move_frame) begin
            collide_top_o    <= 1'b0;
            collide_bottom_o <= 1'b0;
            collide_left_o   <= 1'b0;
            collide_right_o  <= 1'b0;
            moving_o         <= 1'b0;
          end
          stun_cnt <= stun_cnt - STUN_ONE;
          if (stun_cnt == STUN_ONE) state <= StIdle;
        end
        default: begin
          if (move_frame) begin
            player_x_o       <= nx;
            player_y_o       <= ny;
            collide_top_o    <= hit_t;
            collide_bottom_o <= hit_b;
            collide_left_o   <= hit_l;
            collide_right_o  <= hit_r;
            moving_o         <= (nx != player_x_o) || (ny != player_y_o);
            if (any_hit) begin
              state    <= StStun;
              stun_cnt <= STUN_LOAD;
            end else if (nonzero) begin
              state <= StMove;
            end else begin
              state <= StIdle;
            end
          end
        end
      endcase
    end
  end

endmodule
